// File: rtl/pc_sequencer.sv
// Program-counter sequencer with CALL/RET support against an external stack.
// All state advances on the falling edge of nclk; nreset is asynchronous active-low.
// The external stack is assumed to present the entry being popped on stack_data_out
// during the cycle after its count_down edge (RET_LOAD).
module pc_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 8
) (
  input  logic          nclk,
  input  logic          nreset,
  input  logic          instr_valid,
  output logic          ready,
  input  logic [1:0]    opcode,
  input  logic [AW-1:0] target,
  input  logic          clear_fault,
  input  logic [AW-1:0] stack_data_out,
  output logic          stack_push,
  output logic          stack_pop,
  output logic [AW-1:0] stack_data_in,
  output logic [AW-1:0] pc,
  output logic [4:0]    depth,
  output logic          fault
);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StCallPush = 2'b01,
    StRetPop   = 2'b10,
    StRetLoad  = 2'b11
  } state_t;

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpJump = 2'b01;
  localparam logic [1:0] OpCall = 2'b10;
  localparam logic [1:0] OpRet  = 2'b11;

  localparam logic [4:0] DepthMax = 5'(DEPTH);

  state_t state;

  logic          stack_full;
  logic          stack_empty;
  logic [AW-1:0] pc_inc;

  // Helper decodes shared by the FSM
  always_comb begin
    stack_full  = (depth == DepthMax);
    stack_empty = (depth == 5'd0);
    pc_inc      = pc + AW'(1);
  end

  // Instructions are only accepted in IDLE; everything else ignores instr_valid
  assign ready = (state == StIdle);

  // Sequencer FSM with registered stack strobes and return address
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      state         <= StIdle;
      pc            <= '0;
      depth         <= '0;
      fault         <= 1'b0;
      stack_push    <= 1'b0;
      stack_pop     <= 1'b0;
      stack_data_in <= '0;
    end else begin
      // Strobes are single-cycle: they are only raised on entry to their state
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;

      // Clear first so that a fault raised on the same edge wins
      if (clear_fault) begin
        fault <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (instr_valid) begin
            unique case (opcode)
              OpNop: begin
                pc <= pc_inc;
              end
              OpJump: begin
                pc <= target;
              end
              OpCall: begin
                if (stack_full) begin
                  fault <= 1'b1;
                end else begin
                  stack_data_in <= pc_inc;
                  pc            <= target;
                  depth         <= depth + 5'd1;
                  stack_push    <= 1'b1;
                  state         <= StCallPush;
                end
              end
              OpRet: begin
                if (stack_empty) begin
                  fault <= 1'b1;
                end else begin
                  depth     <= depth - 5'd1;
                  stack_pop <= 1'b1;
                  state     <= StRetPop;
                end
              end
              default: ;
            endcase
          end
        end
        StCallPush: begin
          state <= StIdle;
        end
        StRetPop: begin
          state <= StRetLoad;
        end
        StRetLoad: begin
          // Stack pointer has moved on the previous edge; read data is the return address
          pc    <= stack_data_out;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Push and pop are mutually exclusive and tied to their states
  a_push_pop_excl : assert property (@(negedge nclk) disable iff (!nreset)
    !(stack_push && stack_pop));
  a_push_state : assert property (@(negedge nclk) disable iff (!nreset)
    stack_push |-> (state == StCallPush));
  a_pop_state : assert property (@(negedge nclk) disable iff (!nreset)
    stack_pop |-> (state == StRetPop));
  a_depth_range : assert property (@(negedge nclk) disable iff (!nreset)
    depth <= DepthMax);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
- REQ-001: Parameter DEPTH, default 16, SHALL set the number of stack entries tracked by the sequencer.
- REQ-002: Parameter AW, default 8, SHALL set the width of the program counter and the stack data.
- REQ-003: nclk, input, 1, SHALL be the single clock; all state updates occur on its falling edge.
- REQ-004: nreset, input, 1, SHALL be an asynchronous, active-low reset.
- REQ-005: instr_valid, input, 1, SHALL mean an instruction is presented.
- REQ-006: ready, output, 1, SHALL mean the instruction is accepted on the current edge when instr_valid is also high.
- REQ-007: opcode, input, 2, SHALL encode 00 NOP, 01 JUMP, 10 CALL, 11 RET.
- REQ-008: target, input, AW, SHALL carry the JUMP/CALL destination.
- REQ-009: clear_fault, input, 1, SHALL clear the sticky fault flag.
- REQ-010: stack_data_out, input, AW, SHALL be the stack's asynchronous top-of-stack read data.
- REQ-011: stack_push, output, 1, SHALL drive the stack's count_up.
- REQ-012: stack_pop, output, 1, SHALL drive the stack's count_down.
- REQ-013: stack_data_in, output, AW, SHALL be the return address written on push.
- REQ-014: pc, output, AW, SHALL be the current program counter.
- REQ-015: depth, output, 5, SHALL be the number of occupied stack entries (0..DEPTH).
- REQ-016: fault, output, 1, SHALL be the sticky overflow/underflow flag.

Function
- REQ-017: The FSM SHALL have four states: IDLE, CALL_PUSH, RET_POP and RET_LOAD; ready SHALL equal (state==IDLE).
- REQ-018: stack_push, stack_pop and stack_data_in SHALL be registered outputs, decoded only from state and held registers.
- REQ-019: IDLE with an accepted NOP SHALL set pc to pc+1 modulo 2^AW (0xFF wraps to 0x00).
- REQ-020: IDLE with an accepted JUMP SHALL set pc to target; depth and the stack are untouched.
- REQ-021: IDLE with an accepted CALL and depth<DEPTH SHALL, on that edge, latch stack_data_in=pc+1 (mod 2^AW), set pc=target, increment depth, and enter CALL_PUSH.
- REQ-022: CALL_PUSH SHALL assert stack_push for exactly one cycle and then return to IDLE.
- REQ-023: IDLE with an accepted RET and depth>0 SHALL decrement depth and enter RET_POP.
- REQ-024: RET_POP SHALL assert stack_pop for exactly one cycle and then enter RET_LOAD.
- REQ-025: RET_LOAD SHALL load pc from stack_data_out on its closing edge and return to IDLE.
- REQ-026: Latency SHALL be: NOP/JUMP 1 cycle busy-free, CALL ready low for 1 cycle, RET ready low for 2 cycles with pc valid at RET_LOAD exit.
- REQ-027: stack_push and stack_pop SHALL never be asserted simultaneously.
- REQ-028: A CALL with depth==DEPTH (overflow) SHALL set fault, leave pc and depth unchanged, issue no push, and remain in IDLE.
- REQ-029: A RET with depth==0 (underflow) SHALL set fault, leave pc unchanged, issue no pop, and remain in IDLE.
- REQ-030: fault SHALL stay set until clear_fault or reset; if clear_fault coincides with a new fault, set wins.
- REQ-031: instr_valid SHALL be ignored while ready is low; no instruction is queued.

Reset
- REQ-032: While nreset is low, the block SHALL hold pc=0, depth=0, fault=0, stack_push=0, stack_pop=0, stack_data_in=0 and state=IDLE, regardless of nclk.
- REQ-033: A reset asserted during CALL_PUSH, RET_POP or RET_LOAD SHALL abort the operation immediately, with no partial push/pop pulse after release.
- REQ-034: The stack pointer SHALL be re-initialised to 0 together with the sequencer; the system top guarantees this.

Verification
- REQ-035: Release reset -> pc=0x00, depth=0, ready=1, fault=0, stack_push=stack_pop=0.
- REQ-036: pc=0x05, CALL target 0x40 -> next cycle stack_push=1 and stack_data_in=0x06 for one cycle; pc=0x40; depth=1; ready low for 1 cycle.
- REQ-037: Then RET -> stack_pop=1 for one cycle; stack returns 0x06; pc=0x06 at RET_LOAD exit; depth=0; ready low for 2 cycles.
- REQ-038: 16 CALLs then a 17th CALL -> 17th sets fault=1 with no push, depth stays 16, pc unchanged; clear_fault -> fault=0.
- REQ-039: RET at depth=0 -> fault=1, no pop, pc unchanged; NOP at pc=0xFF -> pc=0x00.
- REQ-040: nreset low during RET_POP -> all outputs at reset values at once; after release, no stack_pop pulse and pc=0x00.
